// File: rtl/dc_router_pkg.sv
// dc_router_pkg: shared definitions for the data & control router front end.
//   - OP_* : router instruction op codes (low two bits of `instruction`)
//   - sched_state_e : job scheduler FSM states
//   - job_desc_t : packed 66-bit job descriptor {op, offset, filesize}
//   - op_is_legal() : true for ops the router can execute (FFT, FIR)
package dc_router_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_FFT  = 2'b01;
  localparam logic [1:0] OP_FIR  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] offset;
    logic [31:0] filesize;
  } job_desc_t;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_FFT) || (op == OP_FIR);
  endfunction

endpackage

// File: rtl/dc_job_fifo.sv
// dc_job_fifo: in-order DEPTH x 66-bit job descriptor queue.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (flushes pointers/count)
//   push, din        : write request and descriptor (ignored when full)
//   pop, dout        : read request (ignored when empty); dout shows the head entry
//   full, empty      : occupancy flags derived from the registered count
//   count            : number of entries held
// Push and pop may occur in the same cycle; the count is then unchanged.
module dc_job_fifo
  import dc_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  job_desc_t                  din,
  input  logic                       pop,
  output job_desc_t                  dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  job_desc_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;

  // The head is read combinationally so the scheduler can pop and load it
  // in the same cycle; this keeps the issue latency at two edges.
  assign dout = mem[rd_ptr_reg];

  // Storage has no reset: only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dc_job_scheduler.sv
// dc_job_scheduler: queues accelerator job descriptors from the host and
// issues them one at a time to the data & control router.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   job_valid/job_ready                 : host handshake (transfer when both high)
//   job_op, job_offset, job_filesize    : descriptor fields
//   instruction, offset, filesize       : router job inputs ({30'b0, op} while active)
//   acc_done                            : router completion level
//   busy                                : scheduler not IDLE
//   queue_count                         : queued (not yet issued) jobs
//   job_done / job_err                  : one-cycle completion / rejection pulses
//   done_op                             : op of the most recent pulse
// Build option: define DC_JOB_TIMEOUT_EN to enable the ACTIVE watchdog that
// aborts a job after TIMEOUT_CYCLES cycles without acc_done.
module dc_job_scheduler
  import dc_router_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_op,
  input  logic [31:0]                job_offset,
  input  logic [31:0]                job_filesize,
  output logic [31:0]                instruction,
  output logic [31:0]                offset,
  output logic [31:0]                filesize,
  input  logic                       acc_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       job_done,
  output logic                       job_err,
  output logic [1:0]                 done_op
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Elaboration-time parameter sanity checks.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("dc_job_scheduler: DEPTH must be a power of 2 and at least 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("dc_job_scheduler: GAP_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dc_job_scheduler: TIMEOUT_CYCLES must be at least 1");
  end

  // Pulse event waiting to be reported: err selects job_err over job_done.
  typedef struct packed {
    logic       err;
    logic [1:0] op;
  } evt_t;

  sched_state_e  state_reg, state_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [1:0]    op_reg;
  logic [31:0]   offset_reg;
  logic [31:0]   filesize_reg;

  job_desc_t     in_desc;
  job_desc_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          op_legal;
  logic          push;
  logic          pop;
  logic          filt_valid;
  logic          fin_valid;
  logic          fin_err;
  logic          timeout_hit;

  evt_t          pend_reg  [2];
  evt_t          pend_next [2];
  logic [1:0]    pend_cnt_reg, pend_cnt_next;
  evt_t          new_evt;
  evt_t          out_evt;
  logic          out_valid;
  logic          job_done_reg;
  logic          job_err_reg;
  logic [1:0]    done_op_reg;

  // Host side. The pending-event check only matters if a continuous stream
  // of rejected jobs keeps colliding with completions; it never triggers in
  // ordinary traffic but keeps every pulse from being lost.
  assign job_ready  = !fifo_full && (pend_cnt_reg != 2'd2);
  assign accept     = job_valid && job_ready;
  assign op_legal   = op_is_legal(job_op);
  assign push       = accept && op_legal && (job_filesize != '0);
  assign filt_valid = accept && !(op_legal && (job_filesize != '0));
  assign pop        = (state_reg == IDLE) && !fifo_empty;

  assign in_desc.op       = job_op;
  assign in_desc.offset   = job_offset;
  assign in_desc.filesize = job_filesize;

  dc_job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (in_desc),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (queue_count)
  );

`ifdef DC_JOB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt_reg;

  // The counter holds the number of ACTIVE cycles already completed, so the
  // abort fires on the edge that ends the TIMEOUT_CYCLES-th ACTIVE cycle.
  assign timeout_hit = (state_reg == ACTIVE) && !acc_done &&
                       (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if (pop) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ACTIVE) begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Scheduler FSM. A completion (or abort) loads the gap counter with
  // GAP_CYCLES-1 so GAP lasts GAP_CYCLES edges; it is then extended for as
  // long as acc_done stays high so a stale level cannot end the next job.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    fin_valid  = 1'b0;
    fin_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (acc_done || timeout_hit) begin
          state_next = GAP;
          gap_next   = GW'(GAP_CYCLES - 1);
          fin_valid  = 1'b1;
          fin_err    = !acc_done;
        end
      end
      GAP: begin
        if (gap_reg != '0) begin
          gap_next = gap_reg - GW'(1);
        end else if (!acc_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      gap_reg      <= '0;
      op_reg       <= OP_IDLE;
      offset_reg   <= '0;
      filesize_reg <= '0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
      if (pop) begin
        op_reg       <= head.op;
        offset_reg   <= head.offset;
        filesize_reg <= head.filesize;
      end else if (fin_valid) begin
        op_reg       <= OP_IDLE;
        offset_reg   <= '0;
        filesize_reg <= '0;
      end
    end
  end

  assign instruction = {30'b0, op_reg};
  assign offset      = offset_reg;
  assign filesize    = filesize_reg;
  assign busy        = (state_reg != IDLE);

  // Pulse arbitration: a completion always wins the cycle; rejected-job
  // events wait in a two-entry in-order backlog and are emitted one per
  // cycle, so pulses never merge and each one updates done_op.
  always_comb begin
    new_evt.err   = !op_legal;
    new_evt.op    = job_op;
    pend_next     = pend_reg;
    pend_cnt_next = pend_cnt_reg;
    out_valid     = 1'b0;
    out_evt       = '0;
    if (fin_valid) begin
      out_valid   = 1'b1;
      out_evt.err = fin_err;
      out_evt.op  = op_reg;
    end else if (pend_cnt_reg != 2'd0) begin
      out_valid     = 1'b1;
      out_evt       = pend_reg[0];
      pend_next[0]  = pend_reg[1];
      pend_cnt_next = pend_cnt_reg - 2'd1;
    end else if (filt_valid) begin
      out_valid = 1'b1;
      out_evt   = new_evt;
    end
    // A new event that could not go out directly joins the backlog tail.
    if (filt_valid && (fin_valid || (pend_cnt_reg != 2'd0))) begin
      pend_next[pend_cnt_next[0]] = new_evt;
      pend_cnt_next               = pend_cnt_next + 2'd1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_pend
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pend_reg[gi] <= '0;
      end else begin
        pend_reg[gi] <= pend_next[gi];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt_reg <= 2'd0;
      job_done_reg <= 1'b0;
      job_err_reg  <= 1'b0;
      done_op_reg  <= OP_IDLE;
    end else begin
      pend_cnt_reg <= pend_cnt_next;
      job_done_reg <= out_valid && !out_evt.err;
      job_err_reg  <= out_valid && out_evt.err;
      if (out_valid) begin
        done_op_reg <= out_evt.op;
      end
    end
  end

  assign job_done = job_done_reg;
  assign job_err  = job_err_reg;
  assign done_op  = done_op_reg;

endmodule
